// File: rtl/serial_frame_pkg.sv
// Shared encodings for the serial frame receiver: FSM states, bit-order codes and line idle level.
package serial_frame_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } state_t;

endpackage

// File: rtl/serial_frame_shifter.sv
// WIDTH-bit shift-in register; dir selects whether the first received bit lands in bit 0 or the MSB.
module serial_frame_shifter
    import serial_frame_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift,
    input  logic             dir,
    input  logic             s_in,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (shift) begin
            if (dir == DIR_MSB_FIRST) begin
                q <= {q[WIDTH-2:0], s_in};
            end else begin
                q <= {s_in, q[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits, optional even parity, stop bit.
// Define SERIAL_FRAME_RX_PARITY_EN to add the parity bit and the parity_err output.
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             s_in,
    input  logic             dir,
    output logic [WIDTH-1:0] p_out,
    output logic             valid,
    output logic             frame_err,
`ifdef SERIAL_FRAME_RX_PARITY_EN
    output logic             parity_err,
`endif
    output logic             busy
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             dir_q;
    logic [WIDTH-1:0] shreg;
    logic             shift;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic             par_q;
`endif

    assign shift = enable && (state == DATA);
    assign busy  = (state != IDLE);

    serial_frame_shifter #(
        .WIDTH(WIDTH)
    ) u_shifter (
        .clk  (clk),
        .reset(reset),
        .shift(shift),
        .dir  (dir_q),
        .s_in (s_in),
        .q    (shreg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            dir_q     <= DIR_LSB_FIRST;
            p_out     <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            parity_err <= 1'b0;
            par_q      <= 1'b0;
`endif
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (enable) begin
                case (state)
                    IDLE: begin
                        if (s_in != IDLE_LEVEL) begin
                            state <= DATA;
                            dir_q <= dir;
                            cnt   <= '0;
                        end
                    end
                    DATA: begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(WIDTH - 1)) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
`ifdef SERIAL_FRAME_RX_PARITY_EN
                    PARITY: begin
                        par_q <= s_in;
                        state <= STOP;
                    end
`endif
                    STOP: begin
                        // A low stop bit only flags the error; it never opens a new frame.
                        state <= IDLE;
                        if (s_in == IDLE_LEVEL) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                            if ((^shreg) ^ par_q) begin
                                parity_err <= 1'b1;
                            end else begin
                                p_out <= shreg;
                                valid <= 1'b1;
                            end
`else
                            p_out <= shreg;
                            valid <= 1'b1;
`endif
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx: frames are built from data words and compared
// against expected pulse counts, timing and held word.
module tb_serial_frame_rx;

    localparam int W = 4;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB = W + 2 + PAR;

    logic         clk = 1'b0;
    logic         reset, enable, s_in, dir;
    logic [W-1:0] p_out;
    logic         valid, frame_err, busy, parity_err;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_p;

    int           obs_v, obs_f, obs_pe, obs_both, obs_vidx, obs_dis_pulse, obs_dis_change;
    logic [15:0]  obs_busy;
    logic [W-1:0] obs_p;
    logic [15:0]  exp_busy;

    always #5 clk = ~clk;

    serial_frame_rx #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .s_in      (s_in),
        .dir       (dir),
        .p_out     (p_out),
        .valid     (valid),
        .frame_err (frame_err),
`ifdef SERIAL_FRAME_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy      (busy)
    );

`ifndef SERIAL_FRAME_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    task automatic drive_bit(input logic b, input logic en);
        @(negedge clk);
        s_in   = b;
        enable = en;
        @(posedge clk);
        #1;
    endtask

    // gap: 0 none, 1 one disabled cycle per bit, 2 random 0..2 disabled cycles per bit
    task automatic run_frame(input logic [W-1:0] word, input logic d, input logic stop_b,
                             input logic par_flip, input int gap, input logic scramble);
        logic bits[$];
        logic bprev;
        logic [W-1:0] pprev;
        int   n;
        bits = {};
        bits.push_back(1'b0);
        for (int i = 0; i < W; i++) bits.push_back(d ? word[W-1-i] : word[i]);
        if (PAR != 0) bits.push_back((^word) ^ par_flip);
        bits.push_back(stop_b);
        obs_v = 0; obs_f = 0; obs_pe = 0; obs_both = 0; obs_vidx = -1;
        obs_dis_pulse = 0; obs_dis_change = 0; obs_busy = '0;
        bprev = busy; pprev = p_out;
        dir = d;
        for (int k = 0; k < bits.size(); k++) begin
            if (k > 0 && gap > 0) begin
                n = (gap == 1) ? 1 : $urandom_range(0, 2);
                for (int g = 0; g < n; g++) begin
                    if (scramble) dir = 1'($urandom);
                    drive_bit(1'($urandom), 1'b0);
                    if (valid || frame_err || parity_err) obs_dis_pulse++;
                    if (busy !== bprev || p_out !== pprev) obs_dis_change++;
                end
            end
            if (scramble && k > 0) dir = 1'($urandom);
            drive_bit(bits[k], 1'b1);
            obs_busy[k] = busy;
            if (valid) begin obs_v++; obs_vidx = k; end
            if (frame_err) obs_f++;
            if (parity_err) obs_pe++;
            if (valid && frame_err) obs_both++;
            bprev = busy; pprev = p_out;
        end
        obs_p = p_out;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; s_in = 1'b1; dir = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (p_out !== '0)   begin errors++; $display("FAIL rst_p_out got %b want 0000", p_out); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_frame_err got %b want 0", frame_err); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        @(negedge clk); reset = 1'b0;
        run_frame(4'b0110, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        checks++; if (obs_p !== 4'b0110) begin errors++; $display("FAIL rst_pre_word got %b want 0110", obs_p); end
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b0, 1'b1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_midframe_busy got %b want 1", busy); end
        @(negedge clk); reset = 1'b1; enable = 1'b0; s_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (p_out !== '0)   begin errors++; $display("FAIL rst_abort_p_out got %b want 0000", p_out); end
        checks++; if (valid !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL rst_abort_pulse got v=%b f=%b want 0 0", valid, frame_err); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL rst_abort_busy got %b want 0", busy); end
        @(negedge clk); reset = 1'b0;
        exp_p = '0;
        run_frame(4'b1001, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        exp_p = 4'b1001;
        checks++; if (obs_v !== 1 || obs_vidx !== NB - 1) begin errors++; $display("FAIL rst_next_valid got n=%0d at %0d want 1 at %0d", obs_v, obs_vidx, NB - 1); end
        checks++; if (obs_p !== exp_p) begin errors++; $display("FAIL rst_next_word got %b want %b", obs_p, exp_p); end
    endtask

    task automatic test_lsb_first();
        exp_busy = (16'd1 << (NB - 1)) - 16'd1;
        run_frame(4'b1010, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        exp_p = 4'b1010;
        checks++; if (obs_v !== 1) begin errors++; $display("FAIL lsb_valid_count got %0d want 1", obs_v); end
        checks++; if (obs_vidx !== NB - 1) begin errors++; $display("FAIL lsb_latency got %0d want %0d", obs_vidx, NB - 1); end
        checks++; if (obs_p !== exp_p) begin errors++; $display("FAIL lsb_word got %b want %b", obs_p, exp_p); end
        checks++; if (obs_busy !== exp_busy) begin errors++; $display("FAIL lsb_busy_trace got %b want %b", obs_busy, exp_busy); end
        checks++; if (obs_f !== 0) begin errors++; $display("FAIL lsb_frame_err got %0d want 0", obs_f); end
    endtask

    task automatic test_frame_err();
        exp_busy = (16'd1 << (NB - 1)) - 16'd1;
        run_frame(4'b1111, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        checks++; if (obs_f !== 1) begin errors++; $display("FAIL ferr_count got %0d want 1", obs_f); end
        checks++; if (obs_v !== 0) begin errors++; $display("FAIL ferr_valid got %0d want 0", obs_v); end
        checks++; if (obs_p !== exp_p) begin errors++; $display("FAIL ferr_word_held got %b want %b", obs_p, exp_p); end
        checks++; if (obs_busy !== exp_busy) begin errors++; $display("FAIL ferr_idle got %b want %b", obs_busy, exp_busy); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words [2];
        words[0] = 4'b1010; words[1] = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            run_frame(words[i], 1'b1, 1'b1, 1'b0, 0, 1'b0);
            exp_p = words[i];
            checks++; if (obs_v !== 1 || obs_vidx !== NB - 1) begin errors++; $display("FAIL b2b_valid_%0d got n=%0d at %0d want 1 at %0d", i, obs_v, obs_vidx, NB - 1); end
            checks++; if (obs_p !== exp_p) begin errors++; $display("FAIL b2b_word_%0d got %b want %b", i, obs_p, exp_p); end
        end
    endtask

    task automatic test_enable_gating();
        run_frame(4'b0101, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        exp_p = 4'b0101;
        run_frame(4'b1010, 1'b0, 1'b1, 1'b0, 1, 1'b0);
        exp_p = 4'b1010;
        checks++; if (obs_p !== exp_p) begin errors++; $display("FAIL gate_word got %b want %b", obs_p, exp_p); end
        checks++; if (obs_v !== 1 || obs_vidx !== NB - 1) begin errors++; $display("FAIL gate_valid got n=%0d at %0d want 1 at %0d", obs_v, obs_vidx, NB - 1); end
        checks++; if (obs_dis_pulse !== 0) begin errors++; $display("FAIL gate_disabled_pulse got %0d want 0", obs_dis_pulse); end
        checks++; if (obs_dis_change !== 0) begin errors++; $display("FAIL gate_state_frozen got %0d want 0", obs_dis_change); end
    endtask

    task automatic test_random();
        logic [W-1:0] word;
        logic d, stop_b, flip, good;
        exp_busy = (16'd1 << (NB - 1)) - 16'd1;
        for (int t = 0; t < 30; t++) begin
            word   = W'($urandom);
            d      = 1'($urandom);
            stop_b = ($urandom_range(0, 3) != 0);
            flip   = (PAR != 0) ? 1'($urandom) : 1'b0;
            good   = stop_b && !flip;
            run_frame(word, d, stop_b, flip, $urandom_range(0, 2), 1'b1);
            if (good) exp_p = word;
            checks++; if (obs_v !== int'(good)) begin errors++; $display("FAIL rnd_valid t=%0d got %0d want %0d", t, obs_v, good); end
            checks++; if (obs_f !== int'(!stop_b)) begin errors++; $display("FAIL rnd_frame_err t=%0d got %0d want %0d", t, obs_f, !stop_b); end
            checks++; if (obs_p !== exp_p) begin errors++; $display("FAIL rnd_word t=%0d got %b want %b", t, obs_p, exp_p); end
            checks++; if (obs_busy !== exp_busy) begin errors++; $display("FAIL rnd_busy t=%0d got %b want %b", t, obs_busy, exp_busy); end
            checks++; if (obs_both !== 0 || obs_dis_pulse !== 0 || obs_dis_change !== 0) begin errors++; $display("FAIL rnd_hygiene t=%0d got both=%0d dis=%0d chg=%0d want 0", t, obs_both, obs_dis_pulse, obs_dis_change); end
`ifdef SERIAL_FRAME_RX_PARITY_EN
            checks++; if (obs_pe !== int'(stop_b && flip)) begin errors++; $display("FAIL rnd_parity_err t=%0d got %0d want %0d", t, obs_pe, stop_b && flip); end
`endif
        end
    endtask

`ifdef SERIAL_FRAME_RX_PARITY_EN
    task automatic test_parity();
        run_frame(4'b0011, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        exp_p = 4'b0011;
        checks++; if (obs_v !== 1 || obs_pe !== 0) begin errors++; $display("FAIL par_good got v=%0d pe=%0d want 1 0", obs_v, obs_pe); end
        checks++; if (obs_p !== exp_p) begin errors++; $display("FAIL par_good_word got %b want %b", obs_p, exp_p); end
        run_frame(4'b1100, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        checks++; if (obs_pe !== 1 || obs_v !== 0) begin errors++; $display("FAIL par_bad got pe=%0d v=%0d want 1 0", obs_pe, obs_v); end
        checks++; if (obs_p !== exp_p) begin errors++; $display("FAIL par_bad_word got %b want %b", obs_p, exp_p); end
        run_frame(4'b1100, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        checks++; if (obs_f !== 1 || obs_pe !== 0) begin errors++; $display("FAIL par_stop_precedence got f=%0d pe=%0d want 1 0", obs_f, obs_pe); end
    endtask
`endif

    initial begin
        test_reset();
        test_lsb_first();
        test_frame_err();
        test_back_to_back();
        test_enable_gating();
        test_random();
`ifdef SERIAL_FRAME_RX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
